// File: rtl/i2s_clock_gen_if.sv
// Signal bundle between the I2S clock generator (master) and the receive/transmit stages (slave).
// Optional sync input is present only when I2S_CLOCK_GEN_SYNC_EN is defined.
interface i2s_clock_gen_if;
  logic       en;
`ifdef I2S_CLOCK_GEN_SYNC_EN
  logic       sync;
`endif
  logic       sck;
  logic       ws;
  logic       sample;
  logic       shift;
  logic [5:0] frame_posn;
  logic       frame_start;
  logic       running;

  // Level-sensitive run request; all timing outputs are registered strobes/levels, no handshake.
  modport master (
    output sck, ws, sample, shift, frame_posn, frame_start, running,
    input  en
`ifdef I2S_CLOCK_GEN_SYNC_EN
    , input sync
`endif
  );

  modport slave (
    input  sck, ws, sample, shift, frame_posn, frame_start, running,
    output en
`ifdef I2S_CLOCK_GEN_SYNC_EN
    , output sync
`endif
  );
endinterface

// File: rtl/i2s_clock_gen.sv
// Master-mode I2S SCK/WS generator with sample/shift strobes and frame position.
// Define I2S_CLOCK_GEN_SYNC_EN to add the frame-alignment sync input.
module i2s_clock_gen #(
  parameter int DIVIDER = 4,
  parameter int CLOCKS  = 64
) (
  input  logic               ck,
  input  logic               rst_n,
  i2s_clock_gen_if.master    bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] P_LAST    = 8'(DIVIDER - 1);
  localparam logic [5:0] POSN_MASK = 6'(CLOCKS - 1);
  localparam logic [5:0] POSN_HALF = 6'(CLOCKS / 2);

  state_t     state_q, state_d;
  logic [7:0] p_q, p_d;
  logic       sck_q, sck_d;
  logic       ws_q, ws_d;
  logic       sample_q, sample_d;
  logic       shift_q, shift_d;
  logic [5:0] posn_q, posn_d;
  logic       fstart_q, fstart_d;
  logic       running_q, running_d;

  logic       active;
  logic       tick;
  logic       rise;
  logic       fall;
  logic       wrap;
  logic       leaving;
  logic [5:0] posn_adv;

`ifdef I2S_CLOCK_GEN_SYNC_EN
  logic       pending_q, pending_d;
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      posn_q    <= '0;
      fstart_q  <= 1'b0;
      running_q <= 1'b0;
`ifdef I2S_CLOCK_GEN_SYNC_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      sample_q  <= sample_d;
      shift_q   <= shift_d;
      posn_q    <= posn_d;
      fstart_q  <= fstart_d;
      running_q <= running_d;
`ifdef I2S_CLOCK_GEN_SYNC_EN
      pending_q <= pending_d;
`endif
    end
  end

  always_comb begin
    active = (state_q != IDLE);
    tick   = active && (p_q == P_LAST);
    rise   = tick && !sck_q;
    fall   = tick && sck_q;
`ifdef I2S_CLOCK_GEN_SYNC_EN
    // A pending sync replaces the normal increment with a forced frame restart.
    posn_adv = pending_q ? 6'd0 : ((posn_q + 6'd1) & POSN_MASK);
`else
    posn_adv = (posn_q + 6'd1) & POSN_MASK;
`endif
    wrap = fall && (posn_adv == 6'd0);

    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en) state_d = RUN;
      RUN:     if (!bus.en) state_d = DRAIN;
      DRAIN: begin
        if (bus.en)    state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    leaving = (state_q == DRAIN) && (state_d == IDLE);

    p_d      = p_q;
    sck_d    = sck_q;
    ws_d     = ws_q;
    posn_d   = posn_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    fstart_d = 1'b0;

    if (!active || leaving) begin
      // Parked: counters at their start values, strobes quiet; start-of-frame flagged on entry.
      p_d      = '0;
      sck_d    = 1'b0;
      ws_d     = 1'b0;
      posn_d   = '0;
      fstart_d = !active && bus.en;
    end else begin
      p_d      = tick ? 8'd0 : p_q + 8'd1;
      sck_d    = tick ? !sck_q : sck_q;
      sample_d = rise;
      if (fall) begin
        shift_d  = 1'b1;
        posn_d   = posn_adv;
        ws_d     = (posn_adv >= POSN_HALF);
        fstart_d = (posn_adv == 6'd0);
      end
    end

    running_d = (state_d != IDLE);

`ifdef I2S_CLOCK_GEN_SYNC_EN
    pending_d = active && !leaving && ((pending_q && !fall) || bus.sync);
`endif
  end

  assign bus.sck         = sck_q;
  assign bus.ws          = ws_q;
  assign bus.sample      = sample_q;
  assign bus.shift       = shift_q;
  assign bus.frame_posn  = posn_q;
  assign bus.frame_start = fstart_q;
  assign bus.running     = running_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_i2s_clock_gen.sv
// Scoreboard bench for i2s_clock_gen: two instances (4/64 and 2/32) driven by shared en/rst_n/sync,
// checked every cycle against a time-based model of SCK/frame arithmetic.
module tb_i2s_clock_gen;

  localparam int D_A  = 4;
  localparam int CL_A = 64;
  localparam int D_B  = 2;
  localparam int CL_B = 32;

  logic ck;
  logic rst_n;
  logic en;
  logic sync_in;
  logic [1:0] dbg_state_a;
  logic [1:0] dbg_state_b;

  int compared   = 0;
  int mismatched = 0;

  logic [13:0] exp_q0[$];
  logic [13:0] exp_q1[$];

  // Model state: cycles since RUN entry, idle/drain flags, sync pending.
  int m_c[2];
  bit m_idle[2];
  bit m_drain[2];
  bit m_pend[2];

  i2s_clock_gen_if bus_a ();
  i2s_clock_gen_if bus_b ();

  assign bus_a.en = en;
  assign bus_b.en = en;
`ifdef I2S_CLOCK_GEN_SYNC_EN
  assign bus_a.sync = sync_in;
  assign bus_b.sync = sync_in;
`endif

  i2s_clock_gen #(.DIVIDER(D_A), .CLOCKS(CL_A)) dut_a (
    .ck(ck), .rst_n(rst_n), .bus(bus_a), .dbg_state(dbg_state_a));

  i2s_clock_gen #(.DIVIDER(D_B), .CLOCKS(CL_B)) dut_b (
    .ck(ck), .rst_n(rst_n), .bus(bus_b), .dbg_state(dbg_state_b));

  // Clock / reset
  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Expected outputs c cycles after RUN entry, from SCK period and frame length alone.
  function automatic logic [13:0] exp_vec(input int c, input int d, input int cl, input int st);
    int   h;
    int   posn;
    logic sck_e, sample_e, shift_e, ws_e, fs_e;
    logic [1:0] st_e;
    logic [5:0] posn_e;
    h        = c / d;
    sck_e    = (h % 2) == 1;
    sample_e = (c % d == 0) && (h % 2 == 1);
    shift_e  = (c % d == 0) && (c > 0) && (h % 2 == 0);
    posn     = (c / (2 * d)) % cl;
    ws_e     = posn >= cl / 2;
    fs_e     = (c % (2 * d * cl)) == 0;
    st_e     = 2'(st);
    posn_e   = 6'(posn);
    return {st_e, 1'b1, fs_e, posn_e, shift_e, sample_e, ws_e, sck_e};
  endfunction

  task automatic model_step(input int i);
    int d, cl, fl;
    bit fall, wrap;
    logic [13:0] v;
    d  = (i == 0) ? D_A : D_B;
    cl = (i == 0) ? CL_A : CL_B;
    fl = 2 * d * cl;
    if (!rst_n) begin
      m_idle[i] = 1; m_drain[i] = 0; m_c[i] = 0; m_pend[i] = 0;
    end else if (m_idle[i]) begin
      if (en) begin
        m_idle[i] = 0; m_drain[i] = 0; m_c[i] = 0; m_pend[i] = 0;
      end
    end else begin
      fall = ((m_c[i] + 1) % (2 * d)) == 0;
      wrap = fall && (m_pend[i] || ((m_c[i] + 1) % fl == 0));
      if (m_drain[i] && !en && wrap) begin
        m_idle[i] = 1; m_pend[i] = 0;
      end else begin
        m_c[i]     = (fall && m_pend[i]) ? fl : m_c[i] + 1;
        m_pend[i]  = (m_pend[i] && !fall) || sync_in;
        m_drain[i] = !en;
      end
    end
    v = m_idle[i] ? 14'd0 : exp_vec(m_c[i], d, cl, m_drain[i] ? 2 : 1);
    if (i == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  always @(posedge ck) begin
    model_step(0);
    model_step(1);
  end

  // Scoreboard monitor
  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp_v);
    end
  endtask

  always @(negedge ck) begin
    logic [13:0] act_a, act_b;
    act_a = {dbg_state_a, bus_a.running, bus_a.frame_start, bus_a.frame_posn,
             bus_a.shift, bus_a.sample, bus_a.ws, bus_a.sck};
    act_b = {dbg_state_b, bus_b.running, bus_b.frame_start, bus_b.frame_posn,
             bus_b.shift, bus_b.sample, bus_b.ws, bus_b.sck};
    if (exp_q0.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL out_a_queue_empty t=%0t got=%h expected=entry", $time, act_a);
    end else check("out_a", act_a, exp_q0.pop_front());
    if (exp_q1.size() == 0) begin
      compared++; mismatched++;
      $display("FAIL out_b_queue_empty t=%0t got=%h expected=entry", $time, act_b);
    end else check("out_b", act_b, exp_q1.pop_front());
  end

  // Driver tasks
  task automatic wait_posn(input int v, input bit need_sck);
    bit hit;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge ck);
      if (bus_a.frame_posn == 6'(v) && (!need_sck || bus_a.sck)) hit = 1;
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL wait_posn_%0d timed_out got=%0d expected=%0d", v, bus_a.frame_posn, v);
    end
  endtask

  task automatic wait_idle();
    bit hit;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge ck);
      if (!bus_a.running && !bus_b.running) hit = 1;
    end
    compared++;
    if (!hit) begin
      mismatched++;
      $display("FAIL wait_idle timed_out got=%b%b expected=00", bus_a.running, bus_b.running);
    end
  endtask

  task automatic pulse_sync();
    sync_in = 1'b1;
    @(negedge ck);
    #2 sync_in = 1'b0;
  endtask

  initial begin
    logic [13:0] zero_v;
    rst_n   = 1'b1;
    en      = 1'b0;
    sync_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge ck);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge ck);

    // Start and run two full frames of the 4/64 instance.
    #2 en = 1'b1;
    repeat (1100) @(negedge ck);

    // Drain with re-raise (no gap), then drain to idle.
    wait_posn(10, 0); #2 en = 1'b0;
    wait_posn(40, 0); #2 en = 1'b1;
    wait_posn(10, 0); #2 en = 1'b0;
    wait_idle();
    repeat (5) @(negedge ck);

    // Asynchronous reset mid-frame with sck high, then restart.
    #2 en = 1'b1;
    wait_posn(20, 1);
    #2 rst_n = 1'b0;
    #1 zero_v = {bus_a.running, bus_a.frame_start, bus_a.frame_posn, bus_a.shift,
                 bus_a.sample, bus_a.ws, bus_a.sck, bus_b.running, bus_b.frame_start,
                 bus_b.frame_posn[4:0]};
    check("async_reset", zero_v, 14'd0);
    repeat (2) @(negedge ck);
    #2 rst_n = 1'b1;
    repeat (700) @(negedge ck);

`ifdef I2S_CLOCK_GEN_SYNC_EN
    wait_posn(45, 0);
    #2 pulse_sync();
    repeat (700) @(negedge ck);
`endif

    // Randomized run/stop phases.
    for (int k = 0; k < 25; k++) begin
      #2 en = 1'($urandom_range(0, 1));
`ifdef I2S_CLOCK_GEN_SYNC_EN
      if ($urandom_range(0, 3) == 0) pulse_sync();
`endif
      repeat ($urandom_range(1, 300)) @(negedge ck);
    end

    #2 en = 1'b0;
    wait_idle();
    repeat (4) @(negedge ck);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
